// File: rtl/load_store_unit.sv
// load_store_unit
//   Bridges CPU load/store requests onto a word-wide, byte-addressed data
//   memory. One request is in flight at a time. Sub-word stores become
//   read-modify-write sequences. Load data is lane-selected and extended.
//   Misaligned, out-of-range and illegal-funct3 requests are answered with
//   an error and never touch memory.
//
// Ports
//   clk, rst_n       clock; synchronous active-low reset
//   req_*            request handshake (valid/ready), we, funct3, addr, wdata
//   rsp_*            one-cycle response pulse with load data and error flag
//   mem_*            word-aligned memory strobes, address, write data;
//                    mem_rdata_ip is valid the cycle after mem_ren_op
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_ip,
    output logic        req_ready_op,
    input  logic        req_we_ip,
    input  logic [2:0]  req_funct3_ip,
    input  logic [31:0] req_addr_ip,
    input  logic [31:0] req_wdata_ip,
    output logic        rsp_valid_op,
    output logic [31:0] rsp_rdata_op,
    output logic        rsp_err_op,
    output logic        mem_ren_op,
    output logic        mem_wren_op,
    output logic [31:0] mem_addr_op,
    output logic [31:0] mem_wdata_op,
    input  logic [31:0] mem_rdata_ip
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_DATA, S_WR, S_ERR} state_e;

    state_e      state_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wword_q;   // store data at accept, merged word after DATA

    // ---------------- request classification ----------------
    logic f3_ok, misaligned, out_of_range, req_bad, req_is_sw;

    always_comb begin
        if (req_we_ip)
            f3_ok = (req_funct3_ip == 3'b000) || (req_funct3_ip == 3'b001) ||
                    (req_funct3_ip == 3'b010);
        else
            f3_ok = (req_funct3_ip == 3'b000) || (req_funct3_ip == 3'b001) ||
                    (req_funct3_ip == 3'b010) || (req_funct3_ip == 3'b100) ||
                    (req_funct3_ip == 3'b101);
        // funct3[1:0] encodes width for every legal code: 00 B, 01 H, 10 W
        misaligned   = ((req_funct3_ip[1:0] == 2'b01) && req_addr_ip[0]) ||
                       ((req_funct3_ip[1:0] == 2'b10) && (req_addr_ip[1:0] != 2'b00));
        out_of_range = (req_addr_ip >= 32'(MEM_BYTES));
        req_bad      = !f3_ok || misaligned || out_of_range;
        req_is_sw    = req_we_ip && (req_funct3_ip == 3'b010);
    end

    // ---------------- load lane select / extend ----------------
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;

    always_comb begin
        case (addr_q[1:0])
            2'd0:    lane_b = mem_rdata_ip[7:0];
            2'd1:    lane_b = mem_rdata_ip[15:8];
            2'd2:    lane_b = mem_rdata_ip[23:16];
            default: lane_b = mem_rdata_ip[31:24];
        endcase
        lane_h = addr_q[1] ? mem_rdata_ip[31:16] : mem_rdata_ip[15:0];
        case (f3_q)
            3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
            3'b100:  load_ext = {24'd0, lane_b};
            3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
            3'b101:  load_ext = {16'd0, lane_h};
            default: load_ext = mem_rdata_ip;
        endcase
    end

    // ---------------- sub-word store merge ----------------
    logic [31:0] merged;

    always_comb begin
        merged = mem_rdata_ip;
        if (f3_q[1:0] == 2'b00)
            merged[{addr_q[1:0], 3'b000} +: 8] = wword_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = wword_q[15:0];
    end

    // ---------------- state and latched fields ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'd0;
            wword_q <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_ip) begin
                        we_q    <= req_we_ip;
                        f3_q    <= req_funct3_ip;
                        addr_q  <= req_addr_ip;
                        wword_q <= req_wdata_ip;
                        if (req_bad)        state_q <= S_ERR;
                        else if (req_is_sw) state_q <= S_WR;
                        else                state_q <= S_RD;
                    end
                end
                S_RD:   state_q <= S_DATA;
                S_DATA: begin
                    if (we_q) begin
                        wword_q <= merged;
                        state_q <= S_WR;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;   // WR, ERR
            endcase
        end
    end

    // ---------------- Moore outputs ----------------
    logic load_rsp;
    assign load_rsp     = (state_q == S_DATA) && !we_q;

    assign req_ready_op = (state_q == S_IDLE);
    assign rsp_valid_op = load_rsp || (state_q == S_WR) || (state_q == S_ERR);
    assign rsp_err_op   = (state_q == S_ERR);
    assign rsp_rdata_op = load_rsp ? load_ext : 32'd0;
    // strobes gated by reset so an interrupted transaction never writes
    assign mem_ren_op   = rst_n && (state_q == S_RD);
    assign mem_wren_op  = rst_n && (state_q == S_WR);
    assign mem_addr_op  = {addr_q[31:2], 2'b00};
    assign mem_wdata_op = wword_q;

endmodule
